// File: rtl/ce_sched.sv
// ce_sched: sequencing controller for one CE convolution engine.
// Holds one input window, issues CL_OUT channel ops, packs the in-order results.
module ce_sched #(
    parameter int CL_IN  = 9,
    parameter int KERNEL = 3,
    parameter int CL_OUT = 4,
    parameter int N      = 4,
    parameter int AW     = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              win_valid,
    output logic                              win_ready,
    input  logic [CL_IN*KERNEL*KERNEL*N-1:0]  win_data,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0]  ce_data,
    output logic                              w_rd,
    output logic [AW-1:0]                     w_addr,
    output logic                              ce_en,
    input  logic                              ce_en_out,
    input  logic [N-1:0]                      ce_d_out,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [CL_OUT*N-1:0]               res_data,
    output logic                              busy,
    output logic                              err_ovf
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam int            CW   = $clog2(CL_OUT + 1);
    localparam logic [CW-1:0] LAST = CW'(CL_OUT - 1);
    localparam logic [CW-1:0] FULL = CW'(CL_OUT);

    logic [1:0]    state;
    logic [CW-1:0] iss_cnt;
    logic [CW-1:0] rcv_cnt;

    logic accept;
    logic active;
    logic rcv_full;
    logic take;
    logic unexp;
    logic done_next;

    always_comb begin
        accept    = win_valid && (state == S_IDLE);
        active    = (state == S_ISSUE) || (state == S_DRAIN);
        rcv_full  = (rcv_cnt == FULL);
        take      = ce_en_out && active && !rcv_full;
        unexp     = ce_en_out && !take;
        // look ahead so OUT follows the final result by one cycle
        done_next = rcv_full || (take && (rcv_cnt == LAST));
    end

    always_comb begin
        win_ready = (state == S_IDLE);
        res_valid = (state == S_OUT);
        busy      = (state != S_IDLE);
        w_rd      = (state == S_ISSUE);
        w_addr    = (state == S_ISSUE) ? AW'(iss_cnt) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (accept) state <= S_ISSUE;
                S_ISSUE: if (iss_cnt == LAST) state <= S_DRAIN;
                S_DRAIN: if (done_next) state <= S_OUT;
                S_OUT:   if (res_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_cnt <= '0;
        end else if (accept) begin
            iss_cnt <= '0;
        end else if (state == S_ISSUE) begin
            iss_cnt <= iss_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcv_cnt <= '0;
        end else if (accept) begin
            rcv_cnt <= '0;
        end else if (take) begin
            rcv_cnt <= rcv_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_data <= '0;
        end else if (accept) begin
            ce_data <= win_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_data <= '0;
        end else if (accept) begin
            res_data <= '0;
        end else begin
            for (int k = 0; k < CL_OUT; k++) begin
                if (take && (rcv_cnt == CW'(k))) begin
                    res_data[k*N +: N] <= ce_d_out;
                end
            end
        end
    end

    // channel op fires the cycle after its ROM read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_en <= 1'b0;
        end else begin
            ce_en <= w_rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf <= 1'b0;
        end else if (unexp) begin
            err_ovf <= 1'b1;
        end
    end

endmodule

// File: doc/ce_sched.md
Name: ce_sched

Overview:
- Sequencing controller for one CE convolution engine.
- Accepts one input window (CL_IN*KERNEL*KERNEL features) per valid/ready handshake and holds it on the CE data input.
- Issues CL_OUT CE operations in turn, one per output channel, fetching each channel's weight set from an external 1-cycle-latency weight ROM.
- Collects the CL_OUT in-order CE results into one packed output word, released downstream with a valid/ready handshake.

Parameters:
- CL_IN, 9, input features per window
- KERNEL, 3, kernel side (1/3/5/7)
- CL_OUT, 4, output channels per window (2..64)
- N, 4, data width of input features and of CE results
- AW, 2, weight ROM address width; must satisfy 2**AW >= CL_OUT

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- win_valid  in  1  upstream window valid
- win_ready  out  1  controller can accept a window
- win_data  in  CL_IN*KERNEL*KERNEL*N  window features
- ce_data  out  CL_IN*KERNEL*KERNEL*N  registered window, drives CE data2conv
- w_rd  out  1  weight ROM read strobe
- w_addr  out  AW  weight set index (output channel)
- ce_en  out  1  drives CE en_in; ROM data for that channel is valid in the same cycle
- ce_en_out  in  1  CE en_out
- ce_d_out  in  N  CE d_out
- res_valid  out  1  packed result valid
- res_ready  in  1  downstream accepts result
- res_data  out  CL_OUT*N  channel k in bits [k*N +: N]
- busy  out  1  state != IDLE
- err_ovf  out  1  sticky: unexpected CE result

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all counters=0, ce_data=0, res_data=0, w_rd=0, w_addr=0, ce_en=0, res_valid=0, err_ovf=0. Reset asserted mid-operation aborts immediately; in-flight CE results that arrive after reset release are treated as unexpected.
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: win_ready=1 (combinational from state). On win_valid&&win_ready, latch win_data into ce_data, clear iss_cnt, rcv_cnt and res_data, go to ISSUE. ce_data holds until the next accept.
- ISSUE: w_rd=1 and w_addr=iss_cnt, for iss_cnt=0..CL_OUT-1, one per cycle, with no gaps. ce_en is w_rd delayed one register, so the channel-k operation fires the cycle after its ROM read. After the cycle with iss_cnt=CL_OUT-1, go to DRAIN.
- DRAIN: wait until rcv_cnt==CL_OUT, then go to OUT. The final ce_en pulse is emitted in the first DRAIN cycle.
- Collection runs in any state while rcv_cnt<CL_OUT and a window is active (ISSUE or DRAIN): on ce_en_out=1, write ce_d_out into res_data[rcv_cnt*N +: N] and increment rcv_cnt. Results may return during ISSUE; the CE returns results in issue order.
- OUT: res_valid=1 and res_data stable. On res_ready=1, go to IDLE. res_valid stays high until that handshake.
- Timing: window accepted at cycle 0; w_rd in cycles 1..CL_OUT; ce_en in cycles 2..CL_OUT+1. res_valid rises the cycle after the ce_en_out that makes rcv_cnt==CL_OUT.
- Unexpected result: ce_en_out=1 in IDLE or OUT, or with rcv_cnt==CL_OUT. The data is discarded, res_data is not modified, and err_ovf is set. err_ovf clears only on reset.
- Counters are wide enough to hold CL_OUT, so there is no wrap. At most one window is in flight; win_ready=0 in ISSUE, DRAIN and OUT.

Test Plan:
- Reset, then win_valid with win_data all 1s (CL_OUT=4); CE model returns d_out=k+1 for channel k, latency 3 → w_addr 0,1,2,3 in cycles 1-4; ce_en in cycles 2-5; res_data=16'h4321; res_valid at cycle 9.
- Same as the previous test with res_ready held low for 5 cycles → res_valid and res_data stay stable, win_ready=0; IDLE and win_ready=1 the cycle after res_ready=1.
- Back-to-back windows A then B with res_ready=1 → B accepted the cycle after A's result handshake; ce_data switches to B only at that accept.
- ce_en_out pulse injected in IDLE with ce_d_out=4'hF → err_ovf=1, res_data unchanged; the next normal window still completes correctly.
- rst pulled low during DRAIN after 2 results → all outputs go to reset values without waiting for a clock edge; a new window after release produces a correct result.
- CE latency 1 (results during ISSUE), then latency 10 → res_data correct in both cases; DRAIN length follows the latency.
